// File: rtl/minbd_pkg.sv
// Shared MinBD router definitions: flit format and injection starvation threshold.
package minbd_pkg;
  localparam int FLIT_WIDTH       = 64;
  localparam int INJ_STARVE_LIMIT = 8;

  typedef logic [FLIT_WIDTH-1:0] flit_t;
endpackage

// File: rtl/inject_queue_mem.sv
// DEPTH x WIDTH register file for the injection queue: one write port,
// one asynchronous read port, storage cleared on reset.
module inject_queue_mem
  import minbd_pkg::*;
#(
  parameter int WIDTH = FLIT_WIDTH,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage array, written at the write pointer on a push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_r <= '{default: '0};
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/inject_queue.sv
// Local-injection FIFO for the MinBD router: buffers PE flits, presents the
// oldest to the injection stage and flags a head flit that has waited too long.
module inject_queue
  import minbd_pkg::*;
#(
  parameter int WIDTH        = FLIT_WIDTH,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = INJ_STARVE_LIMIT,
  localparam int CW          = $clog2(DEPTH + 1),
  localparam int AW          = $clog2(DEPTH),
  localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_grant,
  output logic [CW-1:0]    count,
  output logic             starve
);

  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_CNT = SW'(STARVE_LIMIT);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic [SW-1:0] wait_r;
  logic [SW-1:0] wait_nxt_s;
  logic          ready_r;
  logic          valid_r;
  logic          starve_r;
  logic          push_s;
  logic          pop_s;

  // Handshakes use registered flags only, so a full queue never takes a flit
  // even when the head leaves in the same cycle.
  assign push_s = in_valid && ready_r;
  assign pop_s  = out_grant && valid_r;

  inject_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_s),
    .wr_addr (wr_ptr_r),
    .wr_data (in_data),
    .rd_addr (rd_ptr_r),
    .rd_data (out_data)
  );

  // Next occupancy: push and pop together leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Next head wait time: restarts on empty or pop, saturates at the limit.
  always_comb begin
    wait_nxt_s = wait_r;
    if (!valid_r || pop_s) begin
      wait_nxt_s = '0;
    end else if (wait_r != STARVE_CNT) begin
      wait_nxt_s = wait_r + SW'(1);
    end else begin
      wait_nxt_s = wait_r;
    end
  end

  // Pointers, occupancy, wait counter and the registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      wait_r   <= '0;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      starve_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r  <= count_nxt_s;
      wait_r   <= wait_nxt_s;
      ready_r  <= (count_nxt_s < FULL_CNT);
      valid_r  <= (count_nxt_s != '0);
      starve_r <= (wait_nxt_s == STARVE_CNT);
    end
  end

  assign in_ready  = ready_r;
  assign out_valid = valid_r;
  assign count     = count_r;
  assign starve    = starve_r;

endmodule

// File: tb/tb_inject_queue.sv
// Table-driven bench for inject_queue with a scoreboard checking pop order.
module tb_inject_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_grant;
  logic [2:0]  count;
  logic        starve;

  int n_vec;
  int n_err;

  typedef struct {
    bit          rst;
    bit          iv;
    logic [63:0] d;
    bit          g;
    int          c;
    bit          v;
    bit          r;
    logic [63:0] x;
    bit          s;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] sb[$];

  inject_queue #(
    .WIDTH        (64),
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_grant (out_grant),
    .count     (count),
    .starve    (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " count"}, 64'(count), 64'd0);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, " starve"}, 64'(starve), 64'd0);
    chk({tag, " out_data"}, out_data, 64'd0);
  endtask

  // Called at posedge+1: reset is pulsed entirely between clock edges.
  task automatic pulse_reset();
    in_valid  = 1'b0;
    out_grant = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_state("reset");
    sb.delete();
    #1 reset = 1'b0;
  endtask

  function automatic vec_t mk(bit rst, bit iv, logic [63:0] d, bit g,
                              int c, bit v, bit r, logic [63:0] x, bit s);
    vec_t t;
    t.rst = rst; t.iv = iv; t.d = d; t.g = g;
    t.c = c; t.v = v; t.r = r; t.x = x; t.s = s;
    return t;
  endfunction

  task automatic apply(input vec_t t, input int idx);
    if (t.rst) pulse_reset();
    in_valid  = t.iv;
    in_data   = t.d;
    out_grant = t.g;
    #1;
    if (t.iv && in_ready) sb.push_back(t.d);
    if (t.g && out_valid) begin
      if (sb.size() == 0) begin
        chk($sformatf("v%0d pop_unexpected", idx), out_data, 64'hDEAD);
      end else begin
        chk($sformatf("v%0d pop_order", idx), out_data, sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d count", idx), 64'(count), 64'(t.c));
    chk($sformatf("v%0d out_valid", idx), 64'(out_valid), 64'(t.v));
    chk($sformatf("v%0d in_ready", idx), 64'(in_ready), 64'(t.r));
    chk($sformatf("v%0d starve", idx), 64'(starve), 64'(t.s));
    if (t.v) chk($sformatf("v%0d out_data", idx), out_data, t.x);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 64'd0;
    out_grant = 1'b0;
    #3 chk_reset_state("power_on");
    #3 reset = 1'b0;
    @(posedge clk);
    #1;

    // Three pushes, no grant: head stays at the first flit.
    tbl.push_back(mk(1, 1, 64'hA1, 0, 1, 1, 1, 64'hA1, 0));
    tbl.push_back(mk(0, 1, 64'hA2, 0, 2, 1, 1, 64'hA1, 0));
    tbl.push_back(mk(0, 1, 64'hA3, 0, 3, 1, 1, 64'hA1, 0));
    // Fill, then offer 0x05 with a grant while full: no push, one pop.
    tbl.push_back(mk(1, 1, 64'h01, 0, 1, 1, 1, 64'h01, 0));
    tbl.push_back(mk(0, 1, 64'h02, 0, 2, 1, 1, 64'h01, 0));
    tbl.push_back(mk(0, 1, 64'h03, 0, 3, 1, 1, 64'h01, 0));
    tbl.push_back(mk(0, 1, 64'h04, 0, 4, 1, 0, 64'h01, 0));
    tbl.push_back(mk(0, 1, 64'h05, 1, 3, 1, 1, 64'h02, 0));
    tbl.push_back(mk(0, 1, 64'h05, 0, 4, 1, 0, 64'h02, 0));
    tbl.push_back(mk(0, 0, 64'h00, 1, 3, 1, 1, 64'h03, 0));
    tbl.push_back(mk(0, 0, 64'h00, 1, 2, 1, 1, 64'h04, 0));
    tbl.push_back(mk(0, 0, 64'h00, 1, 1, 1, 1, 64'h05, 0));
    tbl.push_back(mk(0, 0, 64'h00, 1, 0, 0, 1, 64'h00, 0));
    // Push and pop together at count 1, then stream 10 flits across the wrap.
    tbl.push_back(mk(1, 1, 64'hB1, 0, 1, 1, 1, 64'hB1, 0));
    tbl.push_back(mk(0, 1, 64'hB2, 1, 1, 1, 1, 64'hB2, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 1, 64'h10 + 64'(i), 1, 1, 1, 1, 64'h10 + 64'(i), 0));
    tbl.push_back(mk(0, 0, 64'h00, 1, 0, 0, 1, 64'h00, 0));
    // Starvation: one flit held un-granted, then granted.
    tbl.push_back(mk(1, 1, 64'hD0, 0, 1, 1, 1, 64'hD0, 0));
    for (int k = 1; k <= 10; k++)
      tbl.push_back(mk(0, 0, 64'h00, 0, 1, 1, 1, 64'hD0, k >= 8));
    tbl.push_back(mk(0, 0, 64'h00, 1, 0, 0, 1, 64'h00, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Mid-operation reset with 3 flits queued and the head waiting 5 cycles.
    pulse_reset();
    apply(mk(0, 1, 64'hE1, 0, 1, 1, 1, 64'hE1, 0), 100);
    apply(mk(0, 1, 64'hE2, 0, 2, 1, 1, 64'hE1, 0), 101);
    apply(mk(0, 1, 64'hE3, 0, 3, 1, 1, 64'hE1, 0), 102);
    apply(mk(0, 0, 64'h00, 0, 3, 1, 1, 64'hE1, 0), 103);
    apply(mk(0, 0, 64'h00, 0, 3, 1, 1, 64'hE1, 0), 104);
    apply(mk(0, 0, 64'h00, 0, 3, 1, 1, 64'hE1, 0), 105);
    #2 reset = 1'b1;
    #1;
    chk("async_reset count", 64'(count), 64'd0);
    chk("async_reset out_valid", 64'(out_valid), 64'd0);
    chk("async_reset starve", 64'(starve), 64'd0);
    chk("async_reset in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    #1 reset = 1'b0;
    apply(mk(0, 1, 64'hC0, 0, 1, 1, 1, 64'hC0, 0), 106);
    apply(mk(0, 0, 64'h00, 1, 0, 0, 1, 64'h00, 0), 107);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inject_queue.md
# inject_queue

Local-injection queue for the MinBD router node. It buffers flits produced by the local processing element and presents the oldest one to the router injection stage, whose pipeline register loads it when the router grants an injection slot. It also tracks how long the head flit has been waiting and raises a starvation flag so the router can force injection.

## Interface

Parameters:
- WIDTH, 64, flit width in bits
- DEPTH, 4, queue capacity in flits; power of two, at least 2
- STARVE_LIMIT, 8, consecutive un-granted cycles before `starve` asserts; at least 1

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  local PE offers a flit
- in_data  in  WIDTH  offered flit
- in_ready  out  1  queue accepts a flit this cycle
- out_valid  out  1  head flit available to router
- out_data  out  WIDTH  head flit
- out_grant  in  1  router loads head into its injection register this cycle
- count  out  $clog2(DEPTH+1)  current occupancy
- starve  out  1  head has waited at least STARVE_LIMIT cycles

## Operation

- Circular buffer, DEPTH entries, read and write pointers of $clog2(DEPTH) bits; pointers wrap DEPTH-1 -> 0.
- Push: `in_valid && in_ready`; write `in_data` at the write pointer, then advance it.
- Pop: `out_grant && out_valid`; advance the read pointer. A grant while `out_valid`=0 is ignored.
- `in_ready` = (count < DEPTH), from registered state only. When full, no push occurs even if a pop happens in the same cycle; there is no bypass.
- `out_valid` = (count != 0). `out_data` = entry at the read pointer. It is only meaningful while `out_valid`=1.
- Count update: +1 for push only, -1 for pop only, unchanged for both or neither. A simultaneous push and pop at count=1 leaves count=1, with the new flit at the head next cycle.
- Starvation counter `wait_cnt`, $clog2(STARVE_LIMIT+1) bits:
  - Cleared when `out_valid`=0 or on a pop.
  - Incremented when `out_valid && !out_grant`.
  - Saturates at STARVE_LIMIT.
  - `starve` = (wait_cnt == STARVE_LIMIT).
- Order is strict FIFO; no flit is dropped or duplicated.
- The block contains no state machine beyond the pointers, count and `wait_cnt`.

## Timing

- Reset values: pointers 0, count 0, wait_cnt 0. Hence `in_ready`=1, `out_valid`=0, `starve`=0, `count`=0, and `out_data`=0 (storage cleared on reset).
- Reset asserted mid-operation discards all queued flits at once; outputs take reset values without waiting for a clock edge.
- Push-to-output latency is 1 cycle. A flit pushed at edge N gives `out_valid`=1 after edge N, even when the queue was empty; there is no combinational fall-through.
- All outputs are functions of registers only; none depends combinationally on an input.
- `starve` first asserts on the cycle after the STARVE_LIMIT-th consecutive un-granted valid cycle. It deasserts the cycle after the grant.

## Structure

- Shared package `minbd_pkg` holds:
  - `FLIT_WIDTH` constant, used as the WIDTH default
  - `INJ_STARVE_LIMIT` constant
  - `flit_t` typedef (logic [FLIT_WIDTH-1:0])
- One sub-module is natural: `inject_queue_mem`, a DEPTH x WIDTH register file with one write port, one asynchronous read port and asynchronous reset.
- Pointer, count and starvation logic stay in `inject_queue`.

## Test plan

- Reset, then push 0xA1, 0xA2, 0xA3 on consecutive cycles with `out_grant`=0 -> count 1,2,3; `out_data`=0xA1 from the cycle after the first push.
- Fill DEPTH=4 with 0x01..0x04, then drive `in_valid` with 0x05 and `out_grant`=1 together -> 0x01 popped, 0x05 not accepted (`in_ready`=0), count=3; the next cycle accepts 0x05.
- Count=1, simultaneous push 0xB2 and pop of 0xB1 -> count stays 1, `out_data`=0xB2 next cycle. Then push and grant continuously over 10 flits to check pointer wrap-around -> output order identical to input order.
- Hold one flit un-granted with STARVE_LIMIT=8 -> `starve` rises after 8 cycles and stays high; a grant drops `starve` and count to 0 the next cycle.
- Queue holding 3 flits with wait_cnt=5; assert `reset` between clock edges -> count=0, `out_valid`=0, `starve`=0 immediately. After release, a push of 0xC0 appears as the head one cycle later.
